// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte buffer and launch sequencer in front of the UART transmitter.
//
// Host logic pushes bytes at clock rate into a circular FIFO. The sequencer pops
// one byte, presents it on tx_din, pulses tx_first for one cycle and then waits for
// a fresh rising edge on tx_done. After GAP_CYCLES idle cycles it launches the next
// byte.
//
// Parameters:
//   DEPTH      FIFO entries (power of two, >= 2)
//   ADDR_W     pointer width, log2(DEPTH)
//   GAP_CYCLES idle cycles after tx_done before the next launch (>= 1)
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   wr_data   byte to enqueue
//   wr_en     enqueue strobe, one byte per cycle
//   clr_ovf   clears the sticky overflow flag
//   full      count == DEPTH
//   empty     count == 0
//   count     bytes stored, not counting the byte in flight
//   overflow  sticky, set when a write is dropped
//   busy      sequencer is not idle
//   tx_din    byte to the transmitter, held from launch to launch
//   tx_first  one-cycle start pulse to the transmitter
//   tx_done   transmitter completion input
module uart_tx_fifo #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  input  logic              clr_ovf,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              busy,
  output logic [7:0]        tx_din,
  output logic              tx_first,
  input  logic              tx_done
);

  // Gap counter only has to hold GAP_CYCLES-1.
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StWaitDone,
    StGap
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              done_q;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [7:0]        din_q, din_d;
  logic              first_q, first_d;

  logic              push;
  logic              pop;
  logic              done_rise;

  assign full      = (count_q == (ADDR_W + 1)'(DEPTH));
  assign empty     = (count_q == '0);
  // full is the pre-edge value, so a write to a full FIFO is dropped even when a
  // pop happens on the same edge.
  assign push      = wr_en & ~full;
  assign pop       = (state_q == StIdle) & ~empty;
  // Only a 0->1 transition counts; a level already high at launch is ignored.
  assign done_rise = tx_done & ~done_q;

  // Sequencer next state.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    din_d   = din_q;
    first_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          din_d   = mem[rd_ptr_q];
          first_d = 1'b1;
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (done_rise) begin
          gap_d   = GapW'(GAP_CYCLES - 1);
          state_d = StGap;
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pointer, occupancy and overflow next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A dropped write wins over a simultaneous clear.
    if (wr_en && full) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      gap_q    <= '0;
      din_q    <= 8'h00;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      done_q   <= tx_done;
      gap_q    <= gap_d;
      din_q    <= din_d;
      first_q  <= first_d;
    end
  end

  // Storage array carries no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign count    = count_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != StIdle);
  assign tx_din   = din_q;
  assign tx_first = first_q;

endmodule
